// File: rtl/clock_divider_pkg.sv
// Shared constants, types and helpers for the clock-enable divider bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clock_divider_pkg;

  // Smallest ratio that still yields a high and a low phase.
  localparam int DIV_MIN = 2;

  // Widest supported ratio register; div_clamp works at this width.
  localparam int DIV_W_MAX = 32;

  // Channel index wide enough for the largest bank (16 channels).
  localparam int CH_IDX_MAX_W = 4;

  typedef logic [CH_IDX_MAX_W-1:0] ch_idx_t;

  // Port width of a channel selector; never narrower than one bit.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Ratios below DIV_MIN are raised to DIV_MIN; there is no upper clamp.
  function automatic logic [DIV_W_MAX-1:0] div_clamp(input logic [DIV_W_MAX-1:0] value);
    return (value < DIV_W_MAX'(DIV_MIN)) ? DIV_W_MAX'(DIV_MIN) : value;
  endfunction

endpackage

// File: rtl/div_channel.sv
// One programmable divider channel: counter, active/pending ratio, registered outputs.
// Latency: outputs registered, one edge after the counter state they decode.
// Backpressure: holds one pending ratio; pend_vld stays high until it is applied.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   en           - run enable; low parks the channel and applies any pending ratio
//   wr_vld       - accepted ratio write (caller guarantees pend_vld was low)
//   wr_dat       - requested ratio, clamped to DIV_MIN on capture
//   pend_vld     - a ratio is waiting for the next period boundary
//   clkdv        - divided waveform, high for floor(N/2) of N cycles
//   clken        - one-cycle strobe in the last low cycle of each period
//   locked       - a full period has completed at the current ratio
module div_channel
  import clock_divider_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr_vld,
  input  logic [CNT_W-1:0] wr_dat,
  output logic             pend_vld,
  output logic             clkdv,
  output logic             clken,
  output logic             locked
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] n_act;
  logic [CNT_W-1:0] n_pend;
  logic             pend_q;
  logic             clkdv_q;
  logic             clken_q;
  logic             locked_q;

  logic [CNT_W-1:0] n_last;
  logic [CNT_W-1:0] n_half;
  logic [CNT_W-1:0] wr_clamped;
  logic             at_wrap;

  // n_act is always >= DIV_MIN, so n_act-1 never underflows and cnt
  // never runs past n_last (ratio changes only happen with cnt forced to 0).
  assign n_last     = n_act - CNT_W'(1);
  assign n_half     = n_act >> 1;
  assign at_wrap    = (cnt == n_last);
  assign wr_clamped = CNT_W'(div_clamp(DIV_W_MAX'(wr_dat)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      n_act    <= CNT_W'(DEF_DIV);
      n_pend   <= '0;
      pend_q   <= 1'b0;
      clkdv_q  <= 1'b0;
      clken_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      if (en) begin
        clkdv_q <= (cnt < n_half);
        clken_q <= at_wrap;
        if (at_wrap) begin
          cnt <= '0;
          if (pend_q) begin
            // New ratio starts a fresh period, so lock must be re-earned.
            n_act    <= n_pend;
            pend_q   <= 1'b0;
            locked_q <= 1'b0;
          end else begin
            locked_q <= 1'b1;
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt      <= '0;
        clkdv_q  <= 1'b0;
        clken_q  <= 1'b0;
        locked_q <= 1'b0;
        // No period is in flight while parked, so a pending ratio is safe to take now.
        if (pend_q) begin
          n_act  <= n_pend;
          pend_q <= 1'b0;
        end
      end

      // Writes are only accepted with pend_q low, so this never races the
      // pend_q clears above; a write landing on a wrap edge waits for the next wrap.
      if (wr_vld) begin
        n_pend <= wr_clamped;
        pend_q <= 1'b1;
      end
    end
  end

  assign pend_vld = pend_q;
  assign clkdv    = clkdv_q;
  assign clken    = clken_q;
  assign locked   = locked_q;

endmodule

// File: rtl/clock_divider_bank.sv
// Multi-channel programmable clock-enable divider with glitch-free ratio updates.
// Latency: outputs registered; a new ratio applies at the end of the current period.
// Backpressure: DIV_RDY_OUT low while the addressed channel holds a pending ratio.
//
// Ports:
//   CLKIN_IN, RSTN_IN - clock, asynchronous active-low reset
//   EN_IN             - per-channel run enable
//   DIV_WR_IN         - ratio write valid
//   DIV_CH_IN         - target channel; out-of-range indices are never ready
//   DIV_VAL_IN        - requested ratio
//   DIV_RDY_OUT       - write accepted when high with DIV_WR_IN (combinational)
//   CLKDV_OUT         - per-channel divided waveform
//   CLKEN_OUT         - per-channel one-cycle period strobe
//   LOCKED_OUT        - per-channel lock indication
module clock_divider_bank
  import clock_divider_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 2
) (
  input  logic                        CLKIN_IN,
  input  logic                        RSTN_IN,
  input  logic [NUM_CH-1:0]           EN_IN,
  input  logic                        DIV_WR_IN,
  input  logic [ch_idx_w(NUM_CH)-1:0] DIV_CH_IN,
  input  logic [CNT_W-1:0]            DIV_VAL_IN,
  output logic                        DIV_RDY_OUT,
  output logic [NUM_CH-1:0]           CLKDV_OUT,
  output logic [NUM_CH-1:0]           CLKEN_OUT,
  output logic [NUM_CH-1:0]           LOCKED_OUT
);

  ch_idx_t           ch_sel;
  logic              wr_acc;
  logic [NUM_CH-1:0] ch_wr_vld;
  logic [NUM_CH-1:0] ch_pend;

  assign ch_sel = ch_idx_t'(DIV_CH_IN);

  // Ready mux: only a matching in-range channel can drive ready high,
  // so indices >= NUM_CH fall through to the default of 0.
  always_comb begin
    DIV_RDY_OUT = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == ch_idx_t'(i)) begin
        DIV_RDY_OUT = ~ch_pend[i];
      end
    end
  end

  assign wr_acc = DIV_WR_IN & DIV_RDY_OUT;

  always_comb begin
    ch_wr_vld = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_wr_vld[i] = wr_acc & (ch_sel == ch_idx_t'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    div_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk      (CLKIN_IN),
      .rst_n    (RSTN_IN),
      .en       (EN_IN[g]),
      .wr_vld   (ch_wr_vld[g]),
      .wr_dat   (DIV_VAL_IN),
      .pend_vld (ch_pend[g]),
      .clkdv    (CLKDV_OUT[g]),
      .clken    (CLKEN_OUT[g]),
      .locked   (LOCKED_OUT[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Self-checking bench for clock_divider_bank: directed scenarios then random traffic.
// Latency: one cycle per stimulus step; outputs sampled 1 time unit after the edge.
// Backpressure: ready is checked against the reference model before every edge.
module tb_clock_divider_bank;

  localparam int NUM_CH  = 3;
  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 2;
  localparam int CHW     = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] en_in = '0;
  logic              div_wr = 1'b0;
  logic [CHW-1:0]    div_ch = '0;
  logic [CNT_W-1:0]  div_val = '0;
  logic              div_rdy;
  logic [NUM_CH-1:0] clkdv;
  logic [NUM_CH-1:0] clken;
  logic [NUM_CH-1:0] locked;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  clock_divider_bank #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .CLKIN_IN    (clk),
    .RSTN_IN     (rst_n),
    .EN_IN       (en_in),
    .DIV_WR_IN   (div_wr),
    .DIV_CH_IN   (div_ch),
    .DIV_VAL_IN  (div_val),
    .DIV_RDY_OUT (div_rdy),
    .CLKDV_OUT   (clkdv),
    .CLKEN_OUT   (clken),
    .LOCKED_OUT  (locked)
  );

  // Reference model: each channel tracks which cycle of its current period
  // comes next, the ratio in force and at most one waiting ratio.
  int              m_ratio [NUM_CH];
  int              m_phase [NUM_CH];
  int              m_wait_val [NUM_CH];
  bit              m_waiting [NUM_CH];
  logic [NUM_CH-1:0] m_dv;
  logic [NUM_CH-1:0] m_ce;
  logic [NUM_CH-1:0] m_lk;

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_ratio[i]    = DEF_DIV;
      m_phase[i]    = 0;
      m_wait_val[i] = 0;
      m_waiting[i]  = 1'b0;
    end
    m_dv = '0;
    m_ce = '0;
    m_lk = '0;
  endfunction

  function automatic logic model_rdy(input int ch);
    if (ch >= NUM_CH) return 1'b0;
    return !m_waiting[ch];
  endfunction

  function automatic void model_step(input logic [NUM_CH-1:0] en, input bit wr,
                                     input int ch, input int val);
    bit accept;
    accept = wr && model_rdy(ch);
    for (int i = 0; i < NUM_CH; i++) begin
      if (!en[i]) begin
        m_phase[i] = 0;
        m_dv[i] = 1'b0;
        m_ce[i] = 1'b0;
        m_lk[i] = 1'b0;
        if (m_waiting[i]) begin
          m_ratio[i]   = m_wait_val[i];
          m_waiting[i] = 1'b0;
        end
      end else begin
        // First floor(N/2) cycles of a period are high; the final cycle strobes.
        m_dv[i] = (m_phase[i] < m_ratio[i] / 2);
        m_ce[i] = (m_phase[i] == m_ratio[i] - 1);
        if (m_phase[i] == m_ratio[i] - 1) begin
          m_phase[i] = 0;
          if (m_waiting[i]) begin
            m_ratio[i]   = m_wait_val[i];
            m_waiting[i] = 1'b0;
            m_lk[i]      = 1'b0;
          end else begin
            m_lk[i] = 1'b1;
          end
        end else begin
          m_phase[i] = m_phase[i] + 1;
        end
      end
    end
    if (accept) begin
      m_wait_val[ch] = (val < 2) ? 2 : val;
      m_waiting[ch]  = 1'b1;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One stimulus step: drive, check ready, clock, advance model, check outputs.
  task automatic cycle(input logic [NUM_CH-1:0] en, input bit wr, input int ch, input int val);
    en_in   = en;
    div_wr  = wr;
    div_ch  = CHW'(ch);
    div_val = CNT_W'(val);
    #1;
    check("rdy", {31'b0, div_rdy}, {31'b0, model_rdy(ch)});
    @(posedge clk);
    model_step(en, wr, ch, val);
    #1;
    check("clkdv", {29'b0, clkdv}, {29'b0, m_dv});
    check("clken", {29'b0, clken}, {29'b0, m_ce});
    check("locked", {29'b0, locked}, {29'b0, m_lk});
  endtask

  task automatic run(input logic [NUM_CH-1:0] en, input int n);
    for (int k = 0; k < n; k++) cycle(en, 1'b0, 0, 0);
  endtask

  initial begin
    logic [NUM_CH-1:0] ren;
    model_reset();

    // Reset state
    #2;
    check("rst_clkdv", {29'b0, clkdv}, 32'h0);
    check("rst_clken", {29'b0, clken}, 32'h0);
    check("rst_locked", {29'b0, locked}, 32'h0);
    for (int c = 0; c < NUM_CH; c++) begin
      div_ch = CHW'(c);
      #1;
      check("rst_rdy", {31'b0, div_rdy}, 32'h1);
    end
    div_ch = CHW'(NUM_CH);
    #1;
    check("rst_rdy_badch", {31'b0, div_rdy}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Default ratio 2 on all channels
    cycle(3'b111, 1'b0, 0, 0);
    check("first_dv", {29'b0, clkdv}, 32'h7);
    check("first_ce", {29'b0, clken}, 32'h0);
    cycle(3'b111, 1'b0, 0, 0);
    check("second_dv", {29'b0, clkdv}, 32'h0);
    check("second_ce", {29'b0, clken}, 32'h7);
    check("lock_after2", {29'b0, locked}, 32'h7);
    run(3'b111, 6);

    // Ratio 5 on ch0, others untouched
    cycle(3'b111, 1'b1, 0, 5);
    div_ch = '0;
    #1;
    check("rdy_pending", {31'b0, div_rdy}, 32'h0);
    run(3'b111, 16);

    // Clamp of 0 and 1 on ch1
    cycle(3'b111, 1'b1, 1, 0);
    run(3'b111, 6);
    cycle(3'b111, 1'b1, 1, 1);
    run(3'b111, 6);

    // Second write while pending is dropped; out-of-range channel ignored
    cycle(3'b111, 1'b1, 0, 7);
    cycle(3'b111, 1'b1, 0, 3);
    cycle(3'b111, 1'b1, 3, 9);
    run(3'b111, 16);

    // Drop enable on ch0 mid-period with a pending ratio
    cycle(3'b111, 1'b1, 0, 4);
    cycle(3'b111, 1'b1, 0, 7);
    cycle(3'b110, 1'b0, 0, 0);
    check("dis_dv0", {31'b0, clkdv[0]}, 32'h0);
    run(3'b110, 3);
    run(3'b111, 16);

    // Asynchronous reset mid-period with a pending write
    cycle(3'b111, 1'b1, 2, 6);
    cycle(3'b111, 1'b0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_clkdv", {29'b0, clkdv}, 32'h0);
    check("arst_clken", {29'b0, clken}, 32'h0);
    check("arst_locked", {29'b0, locked}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    div_ch = 2'd2;
    #1;
    check("arst_rdy", {31'b0, div_rdy}, 32'h1);
    run(3'b111, 10);

    // Random traffic
    ren = 3'b111;
    for (int k = 0; k < 1500; k++) begin
      int ch;
      int val;
      bit wr;
      for (int b = 0; b < NUM_CH; b++) begin
        if ($urandom_range(0, 40) == 0) ren[b] = ~ren[b];
      end
      wr  = ($urandom_range(0, 3) == 0);
      ch  = $urandom_range(0, 3);
      val = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 14);
      cycle(ren, wr, ch, val);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
